// File: rtl/seq_det_ctrl.sv
// ============================================================================
// Module   : seq_det_ctrl
// Brief    : Run-time programmable serial pattern detector with IDLE/RUN/DONE
//            control FSM, valid/ready config port, match counter and limit.
//            Optional build macro NON_OVERLAP_EN: when defined, history and
//            bit counter are cleared after every match (non-overlapping).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0] i_cfg_len,
  input  logic [CNT_W-1:0] i_cfg_limit,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_in,
  input  logic             i_in_valid,
  output logic             o_busy,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_done,
  output logic             o_cfg_err
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam logic [LEN_W-1:0] c_PAT_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] c_MIN_LEN = LEN_W'(2);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_cnt;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_limit;
  logic             r_cfg_ok;
  logic             r_cfg_err;
  logic             r_match;
  logic [CNT_W-1:0] r_mcount;

  logic [PAT_W-1:0] w_hist_nxt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [PAT_W-1:0] w_mask;
  logic             w_hit;
  logic [CNT_W-1:0] w_mcount_inc;
  logic             w_at_limit;
  logic             w_len_ok;

  // Next history/counter values and the completing-bit (hit) decision
  always_comb begin
    w_hist_nxt = {r_hist[PAT_W-2:0], i_in};
    w_cnt_nxt  = (r_cnt == c_PAT_LEN) ? r_cnt : r_cnt + 1'b1;
    w_mask     = '0;
    for (int i = 0; i < PAT_W; i++) begin
      // only the youngest r_len bits take part in the comparison
      w_mask[i] = (LEN_W'(i) < r_len);
    end
    w_hit        = i_in_valid
                   && (((w_hist_nxt ^ r_pat) & w_mask) == '0)
                   && (w_cnt_nxt >= r_len);
    w_mcount_inc = (r_mcount == c_CNT_MAX) ? r_mcount : r_mcount + 1'b1;
    w_at_limit   = (r_limit != '0) && (w_mcount_inc == r_limit);
    w_len_ok     = (i_cfg_len >= c_MIN_LEN) && (i_cfg_len <= c_PAT_LEN);
  end

  // Control FSM together with config, history, counters and match register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_hist    <= '0;
      r_cnt     <= '0;
      r_pat     <= '0;
      r_len     <= '0;
      r_limit   <= '0;
      r_cfg_ok  <= 1'b0;
      r_cfg_err <= 1'b0;
      r_match   <= 1'b0;
      r_mcount  <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_match <= 1'b0;
          // a config handshake takes precedence over a same-cycle start
          if (i_cfg_valid) begin
            if (w_len_ok) begin
              r_pat     <= i_cfg_pattern;
              r_len     <= i_cfg_len;
              r_limit   <= i_cfg_limit;
              r_cfg_ok  <= 1'b1;
              r_cfg_err <= 1'b0;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end else if (i_start && r_cfg_ok && !r_cfg_err) begin
            r_state  <= c_ST_RUN;
            r_hist   <= '0;
            r_cnt    <= '0;
            r_mcount <= '0;
          end
        end
        c_ST_RUN: begin
          r_match <= w_hit;
          if (i_in_valid) begin
`ifdef NON_OVERLAP_EN
            if (w_hit) begin
              r_hist <= '0;
              r_cnt  <= '0;
            end else begin
              r_hist <= w_hist_nxt;
              r_cnt  <= w_cnt_nxt;
            end
`else
            r_hist <= w_hist_nxt;
            r_cnt  <= w_cnt_nxt;
`endif
          end
          if (w_hit) begin
            r_mcount <= w_mcount_inc;
          end
          // stop wins over reaching the limit; a same-cycle hit still counts
          if (i_stop) begin
            r_state <= c_ST_IDLE;
          end else if (w_hit && w_at_limit) begin
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: begin
          r_match <= 1'b0;
          if (i_stop) begin
            r_state <= c_ST_IDLE;
          end else if (i_start) begin
            r_state  <= c_ST_RUN;
            r_hist   <= '0;
            r_cnt    <= '0;
            r_mcount <= '0;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_match <= 1'b0;
        end
      endcase
    end
  end

  assign o_cfg_ready   = (r_state == c_ST_IDLE);
  assign o_busy        = (r_state == c_ST_RUN);
  assign o_done        = (r_state == c_ST_DONE);
  assign o_match       = r_match;
  assign o_match_count = r_mcount;
  assign o_cfg_err     = r_cfg_err;

endmodule

`default_nettype wire

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run-time programmable serial pattern detector with a control FSM. The pattern and length are loaded over a valid/ready config port. Detection is started and stopped by command strobes. The block counts matches and halts at a programmable match limit. It sits in front of the FSM-style detectors and replaces fixed-pattern Moore machines where the pattern must change at run time.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of cfg_len; must satisfy 2^LEN_W > PAT_W
CNT_W, 8, width of match_count and cfg_limit

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous active-high reset
cfg_valid  input  1  config request
cfg_ready  output  1  high only in IDLE
cfg_pattern  input  PAT_W  pattern; bit [len-1] is the oldest bit, bit 0 is the newest
cfg_len  input  LEN_W  pattern length, 2..PAT_W
cfg_limit  input  CNT_W  match limit; 0 = unlimited
start  input  1  begin detection (one-cycle strobe)
stop  input  1  abort detection (one-cycle strobe)
in  input  1  serial data bit
in_valid  input  1  qualifies in
busy  output  1  high in RUN
match  output  1  registered, Moore-style: high one cycle after a completing bit
match_count  output  CNT_W  matches since last start
done  output  1  high in DONE
cfg_err  output  1  sticky: last config attempt had an illegal length

Behaviour:
- Reset: async, active-high. State=IDLE; cfg_ready=1; busy=0; match=0; done=0; cfg_err=0; match_count=0; history, bit counter, pattern, len and limit regs all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_valid&cfg_ready with cfg_len in 2..PAT_W: latch pattern/len/limit; clear cfg_err.
  - Illegal cfg_len: registers unchanged; set cfg_err.
  - start (no concurrent cfg handshake): go to RUN; clear history, bit counter and match_count.
  - If config and start arrive in the same cycle, config wins and start is ignored.
  - start while cfg_err=1 or no valid config loaded since reset: ignored.
- RUN:
  - On each in_valid: history <= {history[PAT_W-2:0], in}; bit counter increments, saturating at PAT_W.
  - Match condition: history_next[len-1:0]==pattern[len-1:0] and counter_next>=len.
  - On match: match=1 next cycle; match_count increments, saturating at all-ones.
  - Overlapping matches are detected by default (pattern 1001 on stream 1001001 yields 2 matches).
  - in_valid=0: no shift and no match; match drops to 0.
  - limit!=0 and match_count_next==limit: go to DONE on the same edge that registers match.
  - stop: go to IDLE, except when a completing bit arrives in the same cycle. Then that match is counted and match pulses once, then go to IDLE. stop has priority over the DONE transition.
- DONE: done=1; match_count held. start restarts RUN and clears the count. stop returns to IDLE. cfg is not accepted (cfg_ready=0).
- cfg_ready=0 in RUN and DONE; cfg_valid is ignored there.
- match is 0 in IDLE and DONE, except for the single pulse registered on the transition edge.
- Latency: completing bit at edge N produces match=1 during cycle N+1.
- rst asserted mid-RUN: immediate return to reset values. The config is lost.

Optional Feature:
NON_OVERLAP_EN
- Defined: after each match, history and bit counter are cleared, so the next match needs len fresh bits. Pattern 1001 on stream 1001001 yields 1 match.
- Undefined: overlapping detection as described above.
- Port list is identical in both builds.

Test Plan:
- Reset mid-RUN after 3 bits -> all outputs at reset values within the same cycle, cfg_ready=1, and a subsequent start without a new config is ignored.
- Config pattern=8'b00001001, len=4, limit=0; start; stream 1,0,0,1,0,0,1 -> match pulses after bits 4 and 7, match_count=2 (with NON_OVERLAP_EN: one pulse after bit 4, count=1).
- Config pattern=2'b11, len=2, limit=3; stream 1,1,1,1,1 -> matches after bits 2, 3 and 4; done=1 after bit 4; bit 5 ignored; count=3.
- Config with cfg_len=1 -> cfg_err=1, start ignored, busy stays 0. Then a legal config -> cfg_err=0.
- RUN with in_valid toggling 1,0,1,0... carrying 1,0,0,1 on the valid cycles -> exactly one match, on the cycle after the 4th valid bit.
- stop in the same cycle as the completing bit -> match=1 for one cycle, count increments, state=IDLE next cycle; cfg_valid during RUN -> no handshake.
